// File: rtl/ddr_channel_arb_if.sv
// Request/response bundle between the DDR channel arbiter, its two requesters and the DDR controller.
// The master modport is the arbiter's view; slave is the requesters/DDR side.
interface ddr_channel_arb_if #(
  parameter int IDX_W  = 19,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8
);
  // Fetch requester
  logic                    pc_index_valid;
  logic [IDX_W-1:0]        pc_index;
  logic                    pc_index_ready;
  logic                    pc_operation_done;
  logic [BEATS*DATA_W-1:0] pc_read_inst;
  // Load/store requester
  logic                    lsu_valid;
  logic [IDX_W-1:0]        lsu_index;
  logic                    lsu_write;
  logic [DATA_W-1:0]       lsu_wdata;
  logic [DATA_W-1:0]       lsu_wmask;
  logic                    lsu_ready;
  logic                    lsu_done;
  logic [DATA_W-1:0]       lsu_rdata;
  // DDR controller
  logic                    ddr_chip_enable;
  logic [IDX_W-1:0]        ddr_index;
  logic                    ddr_write_enable;
  logic                    ddr_burst_mode;
  logic [DATA_W-1:0]       ddr_opstore_data;
  logic [DATA_W-1:0]       ddr_opstore_bm;
  logic                    ddr_ready;
  logic                    ddr_data_valid;
  logic [DATA_W-1:0]       ddr_read_data;
  logic                    ddr_operation_done;

  modport master (
    input  pc_index_valid, pc_index,
    output pc_index_ready, pc_operation_done, pc_read_inst,
    input  lsu_valid, lsu_index, lsu_write, lsu_wdata, lsu_wmask,
    output lsu_ready, lsu_done, lsu_rdata,
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    output ddr_opstore_data, ddr_opstore_bm,
    input  ddr_ready, ddr_data_valid, ddr_read_data, ddr_operation_done
  );

  modport slave (
    output pc_index_valid, pc_index,
    input  pc_index_ready, pc_operation_done, pc_read_inst,
    output lsu_valid, lsu_index, lsu_write, lsu_wdata, lsu_wmask,
    input  lsu_ready, lsu_done, lsu_rdata,
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    input  ddr_opstore_data, ddr_opstore_bm,
    output ddr_ready, ddr_data_valid, ddr_read_data, ddr_operation_done
  );
endinterface

// File: rtl/ddr_channel_arb.sv
// Arbitrates the single DDR channel between instruction fetch (8-beat burst) and the LSU (single beat).
// Optional fetch anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module ddr_channel_arb #(
  parameter int IDX_W      = 19,
  parameter int DATA_W     = 64,
  parameter int BEATS      = 8
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 4
`endif
) (
  input  logic              clock,
  input  logic              reset,
  ddr_channel_arb_if.master bus_if
);

  localparam int CNT_W    = $clog2(BEATS + 1);
  localparam int BEAT_IDX = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic              owner_fetch_q;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic              burst_q;
  logic              ce_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wmask_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [DATA_W-1:0] line_q [BEATS];
  logic [DATA_W-1:0] lsu_rdata_q;
  logic              pc_done_q;
  logic              lsu_done_q;

  logic              fetch_first;
  logic              grant_fetch;
  logic              grant_lsu;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0]        starve_q;
  // Fetch overrides LSU priority once the LSU has had STARVE_MAX grants in a row over it.
  assign fetch_first = (starve_q == 3'(STARVE_MAX));
`else
  assign fetch_first = 1'b0;
`endif

  // Ready is combinational so the requester sees acceptance in its grant cycle.
  always_comb begin
    grant_fetch = 1'b0;
    grant_lsu   = 1'b0;
    if (!reset && state_q == IDLE) begin
      if (bus_if.pc_index_valid && (!bus_if.lsu_valid || fetch_first)) begin
        grant_fetch = 1'b1;
      end else if (bus_if.lsu_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_fetch_q <= 1'b0;
      idx_q         <= '0;
      write_q       <= 1'b0;
      burst_q       <= 1'b0;
      ce_q          <= 1'b0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      beat_cnt_q    <= '0;
      lsu_rdata_q   <= '0;
      pc_done_q     <= 1'b0;
      lsu_done_q    <= 1'b0;
      for (int i = 0; i < BEATS; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      pc_done_q  <= 1'b0;
      lsu_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_fetch || grant_lsu) begin
            owner_fetch_q <= grant_fetch;
            idx_q         <= grant_fetch ? bus_if.pc_index : bus_if.lsu_index;
            write_q       <= grant_lsu & bus_if.lsu_write;
            burst_q       <= grant_fetch;
            ce_q          <= 1'b1;
            wdata_q       <= bus_if.lsu_wdata;
            wmask_q       <= bus_if.lsu_wmask;
            beat_cnt_q    <= '0;
            for (int i = 0; i < BEATS; i++) begin
              line_q[i] <= '0;
            end
            if (grant_lsu) begin
              lsu_rdata_q <= '0;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus_if.ddr_ready) begin
            ce_q    <= 1'b0;
            write_q <= 1'b0;
            burst_q <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus_if.ddr_data_valid) begin
            if (owner_fetch_q) begin
              // Counter saturates at BEATS so surplus beats never wrap onto the line.
              if (beat_cnt_q < CNT_W'(BEATS)) begin
                line_q[beat_cnt_q[BEAT_IDX-1:0]] <= bus_if.ddr_read_data;
                beat_cnt_q <= beat_cnt_q + 1'b1;
              end
            end else begin
              lsu_rdata_q <= bus_if.ddr_read_data;
            end
          end
          if (bus_if.ddr_operation_done) begin
            pc_done_q  <= owner_fetch_q;
            lsu_done_q <= ~owner_fetch_q;
            state_q    <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else if (grant_fetch) begin
      starve_q <= '0;
    end else if (grant_lsu) begin
      starve_q <= bus_if.pc_index_valid ? (starve_q + 3'd1) : 3'd0;
    end
  end
`endif

  assign bus_if.pc_index_ready    = grant_fetch;
  assign bus_if.lsu_ready         = grant_lsu;
  assign bus_if.pc_operation_done = pc_done_q;
  assign bus_if.lsu_done          = lsu_done_q;
  assign bus_if.lsu_rdata         = lsu_rdata_q;
  assign bus_if.ddr_chip_enable   = ce_q;
  assign bus_if.ddr_index         = idx_q;
  assign bus_if.ddr_write_enable  = write_q;
  assign bus_if.ddr_burst_mode    = burst_q;
  assign bus_if.ddr_opstore_data  = wdata_q;
  assign bus_if.ddr_opstore_bm    = wmask_q;

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_line_out
    assign bus_if.pc_read_inst[gi*DATA_W +: DATA_W] = line_q[gi];
  end

endmodule

// File: tb/tb_ddr_channel_arb.sv
// Directed bench for ddr_channel_arb: fetch burst, LSU store/load, tie-break, starvation, short/long bursts, reset mid-op.
module tb_ddr_channel_arb;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [511:0] exp_line;

  always #5 clock = ~clock;

  ddr_channel_arb_if #(.IDX_W(19), .DATA_W(64), .BEATS(8)) bus ();

  ddr_channel_arb dut (
    .clock  (clock),
    .reset  (reset),
    .bus_if (bus)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at an IDLE negedge with a request pending; completes a data-less transaction.
  task automatic txn(input bit drop_pc, input bit drop_lsu, input bit exp_pc_done,
                     input bit exp_lsu_done, input string tag);
    @(negedge clock);
    if (drop_pc)  bus.pc_index_valid = 1'b0;
    if (drop_lsu) bus.lsu_valid      = 1'b0;
    bus.ddr_ready = 1'b1;
    @(negedge clock);
    bus.ddr_ready = 1'b0;
    bus.ddr_operation_done = 1'b1;
    @(negedge clock);
    bus.ddr_operation_done = 1'b0;
    chk({tag, "_pc_done"}, 512'(bus.pc_operation_done), 512'(exp_pc_done));
    chk({tag, "_lsu_done"}, 512'(bus.lsu_done), 512'(exp_lsu_done));
    @(negedge clock);
  endtask

  // Starts at a WAIT negedge; feeds nbeats beats (beat k = k, ninth beat = 0xFF) then op_done.
  task automatic feed_fetch(input int nbeats, input string tag);
    for (int k = 0; k < nbeats; k++) begin
      bus.ddr_data_valid = 1'b1;
      bus.ddr_read_data  = (k < 8) ? 64'(k) : 64'hFF;
      @(negedge clock);
    end
    bus.ddr_data_valid = 1'b0;
    bus.ddr_operation_done = 1'b1;
    @(negedge clock);
    bus.ddr_operation_done = 1'b0;
    exp_line = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < nbeats) exp_line[k*64 +: 64] = 64'(k);
    end
    chk({tag, "_done"}, 512'(bus.pc_operation_done), 512'(1));
    chk({tag, "_line"}, bus.pc_read_inst, exp_line);
    @(negedge clock);
    chk({tag, "_done_drop"}, 512'(bus.pc_operation_done), 512'(0));
    chk({tag, "_line_hold"}, bus.pc_read_inst, exp_line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pc_index_valid = 1'b0;
    bus.pc_index = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_index = '0;
    bus.lsu_write = 1'b0;
    bus.lsu_wdata = '0;
    bus.lsu_wmask = '0;
    bus.ddr_ready = 1'b0;
    bus.ddr_data_valid = 1'b0;
    bus.ddr_read_data = '0;
    bus.ddr_operation_done = 1'b0;

    // Reset
    repeat (2) @(negedge clock);
    chk("rst_ce", 512'(bus.ddr_chip_enable), 512'(0));
    chk("rst_pc_done", 512'(bus.pc_operation_done), 512'(0));
    chk("rst_lsu_done", 512'(bus.lsu_done), 512'(0));
    chk("rst_line", bus.pc_read_inst, 512'(0));
    chk("rst_rdata", 512'(bus.lsu_rdata), 512'(0));
    reset = 1'b0;
    @(negedge clock);

    // Fetch alone, full burst
    bus.pc_index_valid = 1'b1;
    bus.pc_index = 19'h12345;
    #1;
    chk("f1_pc_ready", 512'(bus.pc_index_ready), 512'(1));
    chk("f1_lsu_ready", 512'(bus.lsu_ready), 512'(0));
    @(negedge clock);
    bus.pc_index_valid = 1'b0;
    chk("f1_ce", 512'(bus.ddr_chip_enable), 512'(1));
    chk("f1_idx", 512'(bus.ddr_index), 512'(19'h12345));
    chk("f1_burst", 512'(bus.ddr_burst_mode), 512'(1));
    chk("f1_we", 512'(bus.ddr_write_enable), 512'(0));
    chk("f1_ready_pulse", 512'(bus.pc_index_ready), 512'(0));
    bus.ddr_ready = 1'b1;
    @(negedge clock);
    bus.ddr_ready = 1'b0;
    chk("f1_ce_drop", 512'(bus.ddr_chip_enable), 512'(0));
    feed_fetch(8, "f1");
    $display("txn fetch 8 beats idx 0x12345 done");

    // LSU store
    bus.lsu_valid = 1'b1;
    bus.lsu_index = 19'h00010;
    bus.lsu_write = 1'b1;
    bus.lsu_wdata = 64'hDEADBEEF;
    bus.lsu_wmask = 64'hFFFFFFFF;
    #1;
    chk("st_lsu_ready", 512'(bus.lsu_ready), 512'(1));
    chk("st_pc_ready", 512'(bus.pc_index_ready), 512'(0));
    @(negedge clock);
    bus.lsu_valid = 1'b0;
    chk("st_ce", 512'(bus.ddr_chip_enable), 512'(1));
    chk("st_we", 512'(bus.ddr_write_enable), 512'(1));
    chk("st_burst", 512'(bus.ddr_burst_mode), 512'(0));
    chk("st_idx", 512'(bus.ddr_index), 512'(19'h00010));
    chk("st_data", 512'(bus.ddr_opstore_data), 512'(64'hDEADBEEF));
    chk("st_mask", 512'(bus.ddr_opstore_bm), 512'(64'hFFFFFFFF));
    bus.ddr_ready = 1'b1;
    @(negedge clock);
    bus.ddr_ready = 1'b0;
    bus.ddr_operation_done = 1'b1;
    @(negedge clock);
    bus.ddr_operation_done = 1'b0;
    chk("st_done", 512'(bus.lsu_done), 512'(1));
    chk("st_pc_done", 512'(bus.pc_operation_done), 512'(0));
    @(negedge clock);
    chk("st_done_drop", 512'(bus.lsu_done), 512'(0));
    $display("txn lsu store idx 0x10 done");

    // Tie: LSU load wins, fetch follows after RESP; fetch gets only 5 beats
    bus.lsu_valid = 1'b1;
    bus.lsu_write = 1'b0;
    bus.lsu_index = 19'h00020;
    bus.pc_index_valid = 1'b1;
    bus.pc_index = 19'h00777;
    #1;
    chk("tie_lsu_ready", 512'(bus.lsu_ready), 512'(1));
    chk("tie_pc_ready", 512'(bus.pc_index_ready), 512'(0));
    @(negedge clock);
    bus.lsu_valid = 1'b0;
    chk("tie_pc_wait", 512'(bus.pc_index_ready), 512'(0));
    chk("ld_we", 512'(bus.ddr_write_enable), 512'(0));
    bus.ddr_ready = 1'b1;
    @(negedge clock);
    bus.ddr_ready = 1'b0;
    bus.ddr_data_valid = 1'b1;
    bus.ddr_read_data = 64'hCAFE;
    bus.ddr_operation_done = 1'b1;
    @(negedge clock);
    bus.ddr_data_valid = 1'b0;
    bus.ddr_operation_done = 1'b0;
    chk("ld_done", 512'(bus.lsu_done), 512'(1));
    chk("ld_rdata", 512'(bus.lsu_rdata), 512'(64'hCAFE));
    chk("tie_pc_in_resp", 512'(bus.pc_index_ready), 512'(0));
    @(negedge clock);
    chk("tie_pc_granted", 512'(bus.pc_index_ready), 512'(1));
    @(negedge clock);
    bus.pc_index_valid = 1'b0;
    chk("tie_pc_idx", 512'(bus.ddr_index), 512'(19'h00777));
    bus.ddr_ready = 1'b1;
    @(negedge clock);
    bus.ddr_ready = 1'b0;
    feed_fetch(5, "short");
    chk("ld_rdata_hold", 512'(bus.lsu_rdata), 512'(64'hCAFE));
    $display("txn tie lsu load then fetch 5 beats done");

    // Fetch with a surplus ninth beat
    bus.pc_index_valid = 1'b1;
    bus.pc_index = 19'h00100;
    @(negedge clock);
    bus.pc_index_valid = 1'b0;
    bus.ddr_ready = 1'b1;
    @(negedge clock);
    bus.ddr_ready = 1'b0;
    feed_fetch(9, "long");
    $display("txn fetch 9 beats done");

    // Starvation: fetch held, LSU re-requesting
    bus.pc_index_valid = 1'b1;
    bus.lsu_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      automatic bit exp_fetch = GUARD && (i == 4);
      #1;
      chk($sformatf("starve%0d_pc_ready", i), 512'(bus.pc_index_ready), 512'(exp_fetch));
      chk($sformatf("starve%0d_lsu_ready", i), 512'(bus.lsu_ready), 512'(!exp_fetch));
      txn(exp_fetch, 1'b0, exp_fetch, !exp_fetch, $sformatf("starve%0d", i));
      $display("txn starvation round %0d granted %s", i, exp_fetch ? "fetch" : "lsu");
    end
    bus.lsu_valid = 1'b0;
    #1;
    chk("starve_after_pc_ready", 512'(bus.pc_index_ready), 512'(!GUARD));
    txn(1'b1, 1'b1, !GUARD, 1'b0, "starve_after");
    $display("txn starvation tail done");

    // Reset in WAIT drops the transaction
    bus.pc_index_valid = 1'b1;
    bus.pc_index = 19'h00042;
    @(negedge clock);
    bus.pc_index_valid = 1'b0;
    bus.ddr_ready = 1'b1;
    @(negedge clock);
    bus.ddr_ready = 1'b0;
    bus.ddr_data_valid = 1'b1;
    bus.ddr_read_data = 64'hAA;
    @(negedge clock);
    bus.ddr_data_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("mrst_ce", 512'(bus.ddr_chip_enable), 512'(0));
    chk("mrst_pc_done", 512'(bus.pc_operation_done), 512'(0));
    chk("mrst_line", bus.pc_read_inst, 512'(0));
    reset = 1'b0;
    bus.ddr_operation_done = 1'b1;
    @(negedge clock);
    bus.ddr_operation_done = 1'b0;
    chk("mrst_no_done", 512'(bus.pc_operation_done), 512'(0));
    chk("mrst_ce_idle", 512'(bus.ddr_chip_enable), 512'(0));
    bus.pc_index_valid = 1'b1;
    #1;
    chk("mrst_regrant", 512'(bus.pc_index_ready), 512'(1));
    txn(1'b1, 1'b0, 1'b1, 1'b0, "mrst_after");
    $display("txn reset in WAIT then fresh fetch done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
